gray_counter_gen: RTL

GRAY_COUNTER_GEN -- requirements
Module: gray_counter_gen

---
 rtl/gray_counter_gen.sv | 79 +++++++
 1 files changed

// File: rtl/gray_counter_gen.sv
// Up/down Gray-code counter with clear, load, zero flag and wrap pulse.
// Latency: ps updates one cycle after ns; ns/bin/zero are combinational; wrap is registered or combinational (WRAP_OUT_REG).
// Backpressure: none; en stalls the count and the block accepts a command every cycle.
module gray_counter_gen #(
  parameter int WIDTH        = 3,
  parameter bit WRAP_OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ps,
  output logic [WIDTH-1:0] ns,
  output logic [WIDTH-1:0] bin,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0] ps_q, ps_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] gray_step;
  logic             wrap_evt;

  // Gray-to-binary decode of the present state by prefix XOR from the MSB down.
  // The count is kept only in Gray form, so a loaded Gray value is decoded here
  // on the following cycle and counting resumes correctly from it.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = ps_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ ps_q[i];
    end
  end

  // Next state: clr over load over en, otherwise hold; wrap only on a real count step.
  always_comb begin
    bin_step  = up_dn ? (bin + ONE) : (bin - ONE);
    gray_step = bin_step ^ (bin_step >> 1);
    wrap_evt  = 1'b0;
    ps_d      = ps_q;
    if (clr) begin
      ps_d = ZERO;
    end else if (load) begin
      ps_d = load_val;
    end else if (en) begin
      ps_d     = gray_step;
      wrap_evt = up_dn ? (bin == ALL1) : (bin == ZERO);
    end
    wrap_d = wrap_evt;
  end

  // State and wrap flops; reset abandons the count and any pending wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      wrap_q <= wrap_d;
    end
  end

  // Output mapping; zero is gated by reset so it reads low while reset is held.
  always_comb begin
    ps   = ps_q;
    ns   = ps_d;
    zero = reset & (ps_q == ZERO);
    wrap = WRAP_OUT_REG ? wrap_q : wrap_evt;
  end

endmodule
